operand_fetch_stage: RTL and testbench
======================================

# operand_fetch_stage

Operand fetch stage sitting directly upstream of the 4-way 32-bit operand multiplexer. It holds the 32×32 integer register file and reads rs1/rs2 with write-back bypass. It registers the four mux candidates (rs1 value, rs2 value, immediate, PC) together with the 2-bit select into a one-deep valid/ready output stage that the mux consumes. It also counts back-pressure stall cycles for debug.

## Interface

Parameters:
- XLEN, 32, data width of registers, immediate, PC and outputs
- STALL_W, 16, width of saturating stall counter

Ports:
- clk, in, 1, single clock, all state updates on rising edge
- rst, in, 1, synchronous active-high reset
- in_valid, in, 1, upstream request valid
- in_ready, out, 1, stage can accept this cycle
- in_rs1, in, 5, source register 1 index
- in_rs2, in, 5, source register 2 index
- in_imm, in, XLEN, decoded immediate
- in_pc, in, XLEN, instruction PC
- in_sel, in, 2, operand select forwarded to the mux (00 rs1, 01 rs2, 10 imm, 11 pc)
- wb_en, in, 1, write-back enable
- wb_addr, in, 5, write-back register index
- wb_data, in, XLEN, write-back data
- out_valid, out, 1, output bundle valid
- out_ready, in, 1, downstream mux stage accepts
- out_a, out, XLEN, rs1 value (mux input a)
- out_b, out, XLEN, rs2 value (mux input b)
- out_c, out, XLEN, immediate (mux input c)
- out_d, out, XLEN, PC (mux input d)
- out_sel, out, 2, select (mux input se)
- stall_cnt, out, STALL_W, saturating count of out_valid && !out_ready cycles

Decided: one clock; reset is synchronous and active-high (clk, rst).

## Operation

- Register file: 32 entries × XLEN. x0 always reads 0. Writes to x0 are dropped. Write occurs on the clock edge when wb_en=1 and wb_addr≠0.
- Read with bypass: for each of rs1/rs2, if wb_en=1, wb_addr==rs and rs≠0, the value is wb_data (same-cycle write-first). Otherwise it is the array contents.
- Handshake: in_ready = !out_valid || out_ready, combinational. An accept occurs when in_valid && in_ready. On accept, the output registers load the bypassed rs1/rs2, in_imm, in_pc and in_sel, and out_valid is set to 1.
- Output drain: if out_valid && out_ready and there is no accept, out_valid goes to 0 next cycle. Data registers hold their last values.
- Hold: while out_valid && !out_ready, all out_* are frozen. A write-back to a held register does NOT update out_a/out_b. Ordering hazards are upstream's responsibility.
- The register file write proceeds regardless of handshake state.
- Stall counter: increments by 1 each cycle with out_valid && !out_ready. It saturates at 2^STALL_W−1 and never wraps. It is cleared only by rst.
- Reset (rst=1 at an edge):
  - out_valid=0, out_a..out_d=0, out_sel=0, stall_cnt=0.
  - All 32 registers are cleared to 0.
  - A concurrent wb write is dropped.
  - Any held bundle is discarded.
  - in_ready=1 in the first cycle after reset.

## Timing

- Accept-to-output latency: 1 cycle. Data accepted at edge N is visible on out_* after edge N.
- Throughput: 1 bundle/cycle when out_ready is held high. A simultaneous drain and accept replace the bundle with no bubble.
- Write-back to read-visible latency: 0 cycles via bypass. From the edge after the write onward, the array supplies the value.
- in_ready depends combinationally on out_valid (registered) and out_ready only. No path from in_valid to in_ready.
- stall_cnt updates on the same edge as the stall condition is sampled.

## Test plan

- Reset: hold rst 2 cycles with wb_en=1, wb_addr=5. Then read rs1=5, rs2=0 → out_a=0, out_b=0, out_valid=1 one cycle after accept, stall_cnt=0.
- x0 and basic read: write x0←0xDEADBEEF, then x7←0x12345678. Read rs1=0, rs2=7, imm=0x10, pc=0x400, sel=2'b11 → out_a=0, out_b=0x12345678, out_c=0x10, out_d=0x400, out_sel=3.
- Bypass: in the same cycle, wb x3←0xCAFEF00D and accept rs1=3, rs2=3 → out_a=out_b=0xCAFEF00D. Next read of x3 without wb → 0xCAFEF00D.
- Back-pressure: accept bundle with rs1=7, then hold out_ready=0 for 4 cycles while writing x7←0x1 and offering new in_valid. Expect:
  - in_ready=0 and out_a unchanged (0x12345678).
  - stall_cnt=4.
  - Raising out_ready drains, and the new bundle appears next cycle with out_a=0x1.
- Streaming: out_ready=1, in_valid=1 for 8 cycles with rs1=1..8 → 8 consecutive valid outputs, no bubbles, in_ready constantly 1.
- Saturation and reset mid-stall: STALL_W=3, stall 10 cycles → stall_cnt=7 and holds. Assert rst during the stall → next cycle out_valid=0, stall_cnt=0, in_ready=1.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: 32-entry register file with write-back bypass,
// feeding a one-deep valid/ready output register that holds the four
// operand-mux candidates and their select. Also counts stall cycles.
module operand_fetch_stage #(
    parameter int XLEN    = 32,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [XLEN-1:0]    in_imm,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [1:0]         in_sel,
    input  logic               wb_en,
    input  logic [4:0]         wb_addr,
    input  logic [XLEN-1:0]    wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_a,
    output logic [XLEN-1:0]    out_b,
    output logic [XLEN-1:0]    out_c,
    output logic [XLEN-1:0]    out_d,
    output logic [1:0]         out_sel,
    output logic [STALL_W-1:0] stall_cnt
);

    localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

    logic [XLEN-1:0]    rf_q [32];
    logic [XLEN-1:0]    rf_d [32];

    logic               out_valid_q, out_valid_d;
    logic [XLEN-1:0]    out_a_q, out_a_d;
    logic [XLEN-1:0]    out_b_q, out_b_d;
    logic [XLEN-1:0]    out_c_q, out_c_d;
    logic [XLEN-1:0]    out_d_q, out_d_d;
    logic [1:0]         out_sel_q, out_sel_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

    logic               wb_write;
    logic               accept;
    logic [XLEN-1:0]    rs1_val;
    logic [XLEN-1:0]    rs2_val;

    assign wb_write = wb_en && (wb_addr != 5'd0);

    // Register file next state: write-back lands regardless of handshake; x0 never written
    always_comb begin
        rf_d = rf_q;
        if (wb_write) begin
            rf_d[wb_addr] = wb_data;
        end
    end

    // Source operand reads: x0 is hard zero, same-cycle write-back wins over the array
    always_comb begin
        rs1_val = rf_q[in_rs1];
        rs2_val = rf_q[in_rs2];
        if (in_rs1 == 5'd0) begin
            rs1_val = '0;
        end else if (wb_write && (wb_addr == in_rs1)) begin
            rs1_val = wb_data;
        end
        if (in_rs2 == 5'd0) begin
            rs2_val = '0;
        end else if (wb_write && (wb_addr == in_rs2)) begin
            rs2_val = wb_data;
        end
    end

    // Handshake: ready depends only on registered valid and downstream ready
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Output stage next state: load on accept, clear valid on drain, otherwise hold
    always_comb begin
        out_valid_d = out_valid_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_c_d     = out_c_q;
        out_d_d     = out_d_q;
        out_sel_d   = out_sel_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_a_d     = rs1_val;
            out_b_d     = rs2_val;
            out_c_d     = in_imm;
            out_d_d     = in_pc;
            out_sel_d   = in_sel;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Stall counter next state: count held-bundle cycles, saturating at all-ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
    end

    // State registers; reset clears everything and drops any concurrent write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_c_q     <= '0;
            out_d_q     <= '0;
            out_sel_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            rf_q        <= rf_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_c_q     <= out_c_d;
            out_d_q     <= out_d_d;
            out_sel_q   <= out_sel_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_c     = out_c_q;
    assign out_d     = out_d_q;
    assign out_sel   = out_sel_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: stimulus pushes expected bundles,
// a negedge monitor compares whatever the DUT presents against the queue front.
module tb_operand_fetch_stage;

    localparam int XLEN    = 32;
    localparam int STALL_W = 3;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] c;
        logic [XLEN-1:0] d;
        logic [1:0]      sel;
    } bundle_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [4:0]         in_rs1;
    logic [4:0]         in_rs2;
    logic [XLEN-1:0]    in_imm;
    logic [XLEN-1:0]    in_pc;
    logic [1:0]         in_sel;
    logic               wb_en;
    logic [4:0]         wb_addr;
    logic [XLEN-1:0]    wb_data;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_a;
    logic [XLEN-1:0]    out_b;
    logic [XLEN-1:0]    out_c;
    logic [XLEN-1:0]    out_d;
    logic [1:0]         out_sel;
    logic [STALL_W-1:0] stall_cnt;

    int      n_compared   = 0;
    int      n_mismatched = 0;
    bundle_t exp_q[$];

    operand_fetch_stage #(.XLEN(XLEN), .STALL_W(STALL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .in_pc     (in_pc),
        .in_sel    (in_sel),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_d     (out_d),
        .out_sel   (out_sel),
        .stall_cnt (stall_cnt)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    // Direct comparison of a single observed value against a bench constant
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and record the bundle it must eventually produce
    task automatic driveBundle(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] imm, input logic [31:0] pc, input logic [1:0] sel,
                               input logic [31:0] exp_a, input logic [31:0] exp_b);
        bundle_t e;
        in_valid = 1'b1;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
        in_pc    = pc;
        in_sel   = sel;
        e.a   = exp_a;
        e.b   = exp_b;
        e.c   = imm;
        e.d   = pc;
        e.sel = sel;
        exp_q.push_back(e);
    endtask

    // Present a request and hold it until the stage takes it (bounded wait)
    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [31:0] imm, input logic [31:0] pc, input logic [1:0] sel,
                                 input logic [31:0] exp_a, input logic [31:0] exp_b);
        logic taken;
        taken = 1'b0;
        driveBundle(rs1, rs2, imm, pc, sel, exp_a, exp_b);
        for (int n = 0; n < 50 && !taken; n++) begin
            @(negedge clk);
            taken = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checkOutput("accept_within_budget", {31'd0, taken}, 32'd1);
    endtask

    // Monitor: every presented bundle must match the queue front; pop on transfer
    initial begin
        bundle_t got;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                got = {out_a, out_b, out_c, out_d, out_sel};
                n_compared++;
                if (exp_q.size() == 0) begin
                    n_mismatched++;
                    $display("[TB] FAIL unexpected_bundle: got a=%h b=%h c=%h d=%h sel=%0d, expected none",
                             out_a, out_b, out_c, out_d, out_sel);
                end else begin
                    if (got !== exp_q[0]) begin
                        n_mismatched++;
                        $display("[TB] FAIL bundle: got a=%h b=%h c=%h d=%h sel=%0d, expected a=%h b=%h c=%h d=%h sel=%0d",
                                 out_a, out_b, out_c, out_d, out_sel,
                                 exp_q[0].a, exp_q[0].b, exp_q[0].c, exp_q[0].d, exp_q[0].sel);
                    end
                    if (out_ready === 1'b1) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // Directed stimulus sequence
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_imm    = '0;
        in_pc     = '0;
        in_sel    = '0;
        out_ready = 1'b1;
        wb_en     = 1'b1;
        wb_addr   = 5'd5;
        wb_data   = 32'hAAAA_5555;

        // Reset for two edges with a write-back pending; it must be dropped
        tick();
        tick();
        rst   = 1'b0;
        wb_en = 1'b0;
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_stall_cnt", {29'd0, stall_cnt}, 32'd0);
        checkOutput("reset_out_a", out_a, 32'd0);
        applyStimulus(5'd5, 5'd0, 32'h0, 32'h0, 2'b00, 32'h0, 32'h0);

        // x0 write is dropped, x7 write lands
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
        tick();
        wb_addr = 5'd7; wb_data = 32'h1234_5678;
        tick();
        wb_en = 1'b0;
        applyStimulus(5'd0, 5'd7, 32'h10, 32'h400, 2'b11, 32'h0, 32'h1234_5678);

        // Same-cycle bypass, then array read of the same register
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hCAFE_F00D;
        applyStimulus(5'd3, 5'd3, 32'h20, 32'h404, 2'b01, 32'hCAFE_F00D, 32'hCAFE_F00D);
        wb_en = 1'b0;
        applyStimulus(5'd3, 5'd0, 32'h24, 32'h408, 2'b00, 32'hCAFE_F00D, 32'h0);

        // Back-pressure: hold 4 cycles while x7 changes and a new request waits
        applyStimulus(5'd7, 5'd0, 32'h30, 32'h40C, 2'b00, 32'h1234_5678, 32'h0);
        out_ready = 1'b0;
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h1;
        driveBundle(5'd7, 5'd0, 32'h34, 32'h410, 2'b10, 32'h1, 32'h0);
        @(negedge clk);
        checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        wb_en = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("hold_stall_cnt", {29'd0, stall_cnt}, 32'd4);
        checkOutput("hold_in_ready_late", {31'd0, in_ready}, 32'd0);
        checkOutput("hold_out_a", out_a, 32'h1234_5678);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checkOutput("drain_out_a", out_a, 32'h1);
        checkOutput("drain_stall_cnt", {29'd0, stall_cnt}, 32'd4);

        // Streaming: write x1..x8 then read them back-to-back with no bubbles
        wb_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            wb_addr = 5'(i);
            wb_data = 32'h100 + 32'(i);
            tick();
        end
        wb_en = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            driveBundle(5'(i), 5'd0, 32'(i), 32'(i * 4), 2'(i % 4), 32'h100 + 32'(i), 32'h0);
            @(negedge clk);
            checkOutput("stream_in_ready", {31'd0, in_ready}, 32'd1);
            if (i > 1) begin
                checkOutput("stream_out_valid", {31'd0, out_valid}, 32'd1);
            end
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("stream_last_valid", {31'd0, out_valid}, 32'd1);
        tick();

        // Saturation: hold a bundle for 12 cycles, counter stops at 7
        applyStimulus(5'd2, 5'd1, 32'h50, 32'h500, 2'b01, 32'h102, 32'h101);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        checkOutput("sat_stall_cnt", {29'd0, stall_cnt}, 32'd7);
        tick();
        tick();
        checkOutput("sat_stall_hold", {29'd0, stall_cnt}, 32'd7);
        checkOutput("sat_in_ready", {31'd0, in_ready}, 32'd0);

        // Reset during the stall discards the held bundle and clears the array
        rst = 1'b1;
        tick();
        exp_q.delete();
        rst = 1'b0;
        checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_stall_cnt", {29'd0, stall_cnt}, 32'd0);
        checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        applyStimulus(5'd7, 5'd3, 32'h55, 32'h77, 2'b10, 32'h0, 32'h0);
        tick();
        tick();

        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
